// File: rtl/lvds_test_pkg.sv
// Shared types and constants for the LVDS lane loopback self-test.
//   state_t      : sweep controller states
//   PRBS7_SEED   : generator start value after every reseed
//   PRBS7_TAP_*  : feedback taps of x^7 + x^6 + 1 (bit indices into the 7-bit register)
package lvds_test_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    CHECK  = 3'd2,
    RECORD = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [6:0] PRBS7_SEED  = 7'h7F;
  localparam int         PRBS7_TAP_A = 6;
  localparam int         PRBS7_TAP_B = 5;

endpackage

// File: rtl/lvds_pattern_gen.sv
// Test pattern source for one LVDS lane.
// Build option: LVDS_TEST_PRBS7_EN defined -> PRBS7 (x^7+x^6+1, seed 7'h7F, MSB out);
//               undefined                  -> toggle 1,0,1,0... starting at 1.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-low reset (generator returns to seed)
//   reseed   in  restart the sequence; pat_bit shows the first bit in this same cycle
//   advance  in  the current bit is consumed this cycle, step to the next one
//   pat_bit  out bit to transmit in the current cycle
module lvds_pattern_gen
  import lvds_test_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic reseed,
  input  logic advance,
  output logic pat_bit
);

`ifdef LVDS_TEST_PRBS7_EN
  logic [6:0] lfsr_q;
  logic [6:0] lfsr_cur;

  // Reseed acts combinationally so the first sequence bit is usable on the
  // same edge that starts a lane.
  always_comb lfsr_cur = reseed ? PRBS7_SEED : lfsr_q;
  assign pat_bit = lfsr_cur[6];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= PRBS7_SEED;
    end else if (reseed || advance) begin
      lfsr_q <= {lfsr_cur[5:0], lfsr_cur[PRBS7_TAP_A] ^ lfsr_cur[PRBS7_TAP_B]};
    end
  end
`else
  logic tog_q;
  logic tog_cur;

  always_comb tog_cur = reseed ? 1'b1 : tog_q;
  assign pat_bit = tog_cur;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tog_q <= 1'b1;
    end else if (reseed || advance) begin
      tog_q <= ~tog_cur;
    end
  end
`endif

endmodule

// File: rtl/lvds_lane_test_ctrl.sv
// Per-lane LVDS loopback self-test sequencer.
// Drives a pattern onto one tx lane at a time, compares the returning rx lane
// against the pattern delayed by the loop latency, counts mismatches and
// builds a pass mask. Pattern type selected by LVDS_TEST_PRBS7_EN (see
// lvds_pattern_gen); ports and timing are identical in both builds.
//
// state  | meaning
// IDLE   | waiting for start, tx lanes quiet
// FLUSH  | pattern driven, waiting LOOP_LAT cycles for the loop to fill
// CHECK  | 2**WIN_LOG2 cycles comparing rx against delayed pattern
// RECORD | latch lane result, pick next lane or finish
// DONE   | one-cycle done pulse, then back to IDLE
//
// Ports:
//   clk, rst   clock / asynchronous active-low reset
//   start      pulse, accepted in IDLE only
//   abort      level, forces IDLE from any state
//   rx_data    returning lanes, synchronous to clk
//   tx_data    outgoing lanes (registered), only the lane under test toggles
//   busy       high while a sweep is running (through the DONE cycle)
//   done       one-cycle pulse at sweep completion
//   lane_o     last recorded lane
//   err_cnt_o  saturating mismatch count of the last recorded lane
//   pass_mask  bit i set when lane i recorded zero mismatches this sweep
module lvds_lane_test_ctrl
  import lvds_test_pkg::*;
#(
  parameter  int LANES    = 4,
  parameter  int WIN_LOG2 = 10,
  parameter  int LOOP_LAT = 4,
  parameter  int ERR_W    = 16,
  localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [LANES-1:0]  rx_data,
  output logic [LANES-1:0]  tx_data,
  output logic              busy,
  output logic              done,
  output logic [LANE_W-1:0] lane_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [LANES-1:0]  pass_mask
);

  localparam int CNT_W = (WIN_LOG2 > $clog2(LOOP_LAT)) ? WIN_LOG2 : $clog2(LOOP_LAT);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(LOOP_LAT - 1);
  localparam logic [CNT_W-1:0] CHECK_LOAD = CNT_W'((1 << WIN_LOG2) - 1);

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [LOOP_LAT-1:0] dly_q;
  logic [ERR_W-1:0]    err_q;
  logic [LANES-1:0]    tx_d;
  logic                enter_flush;
  logic                pat_run;
  logic                pat_bit;
  logic                mismatch;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FLUSH;
      FLUSH:   if (cnt_q == '0) state_d = CHECK;
      CHECK:   if (cnt_q == '0) state_d = RECORD;
      RECORD:  state_d = (lane_q == LANE_W'(LANES - 1)) ? DONE : FLUSH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    lane_d = lane_q;
    if (state_q == IDLE && state_d == FLUSH) lane_d = '0;
    else if (state_q == RECORD && state_d == FLUSH) lane_d = lane_q + 1'b1;
  end

  assign enter_flush = (state_d == FLUSH) && (state_q != FLUSH);
  // Pattern bit is consumed on every edge that leads into a FLUSH/CHECK cycle,
  // so the registered tx_data carries one fresh bit per FLUSH/CHECK cycle.
  assign pat_run     = (state_d == FLUSH) || (state_d == CHECK);

  lvds_pattern_gen u_pat (
    .clk     (clk),
    .rst     (rst),
    .reseed  (enter_flush),
    .advance (pat_run),
    .pat_bit (pat_bit)
  );

  always_comb begin
    tx_d = '0;
    if (pat_run) tx_d = LANES'(pat_bit) << lane_d;
  end

  // dly_q[LOOP_LAT-1] holds the bit this lane transmitted LOOP_LAT cycles ago.
  assign mismatch = (state_q == CHECK) && (rx_data[lane_q] != dly_q[LOOP_LAT-1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      tx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      tx_data <= tx_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (enter_flush) begin
      cnt_q <= FLUSH_LOAD;
    end else if (state_q == FLUSH && state_d == CHECK) begin
      cnt_q <= CHECK_LOAD;
    end else if ((state_q == FLUSH || state_q == CHECK) && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_q <= '0;
    end else begin
      dly_q[0] <= tx_data[lane_q];
      for (int i = 1; i < LOOP_LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= '0;
    end else if (enter_flush) begin
      err_q <= '0;
    end else if (mismatch && err_q != {ERR_W{1'b1}}) begin
      err_q <= err_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_o <= '0;
      lane_o    <= '0;
      pass_mask <= '0;
    end else if (state_q == IDLE && state_d == FLUSH) begin
      pass_mask <= '0;
    end else if (state_q == RECORD && !abort) begin
      err_cnt_o         <= err_q;
      lane_o            <= lane_q;
      pass_mask[lane_q] <= (err_q == '0);
    end
  end

endmodule

// File: tb/tb_lvds_lane_test_ctrl.sv
module tb_lvds_lane_test_ctrl;

  localparam int LANES    = 4;
  localparam int WIN_LOG2 = 4;
  localparam int LOOP_LAT = 4;
  localparam int ERR_W    = 3;
  localparam int LW       = 2;
  localparam int WIN      = 1 << WIN_LOG2;
  localparam int LSPAN    = LOOP_LAT + WIN + 1;   // cycles per lane: flush + check + record
  localparam int TOT      = LANES * LSPAN;        // sweep offset of the DONE cycle
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [LANES-1:0] rx_data = '0;
  logic [LANES-1:0] tx_data;
  logic             busy;
  logic             done;
  logic [LW-1:0]    lane_o;
  logic [ERR_W-1:0] err_cnt_o;
  logic [LANES-1:0] pass_mask;

  always #5 clk = ~clk;

  lvds_lane_test_ctrl #(
    .LANES(LANES), .WIN_LOG2(WIN_LOG2), .LOOP_LAT(LOOP_LAT), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .rx_data(rx_data),
    .tx_data(tx_data), .busy(busy), .done(done), .lane_o(lane_o),
    .err_cnt_o(err_cnt_o), .pass_mask(pass_mask)
  );

  int n_vec = 0;
  int n_miss = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pattern bit number i after a reseed.
  function automatic logic pat(input int i);
`ifdef LVDS_TEST_PRBS7_EN
    logic [6:0] s;
    s = 7'h7F;
    for (int k = 0; k < i; k++) s = {s[5:0], s[6] ^ s[5]};
    return s[6];
`else
    return (i % 2) == 0;
`endif
  endfunction

  // Behavioural model: a sweep is a timeline of offsets 0..TOT; offset o
  // belongs to lane o/LSPAN at position o%LSPAN within that lane.
  bit               m_active;
  int               m_t;
  logic [ERR_W-1:0] m_err, m_err_o;
  logic [LW-1:0]    m_lane_o;
  logic [LANES-1:0] m_pass;
  logic [LANES-1:0] exp_tx;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0; m_t <= 0; m_err <= '0; m_err_o <= '0; m_lane_o <= '0; m_pass <= '0;
    end else if (abort) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1; m_t <= 0; m_err <= '0; m_pass <= '0;
      end
    end else if (m_t == TOT) begin
      m_active <= 1'b0;
    end else begin
      m_t <= m_t + 1;
      if ((m_t % LSPAN) >= LOOP_LAT && (m_t % LSPAN) < LOOP_LAT + WIN) begin
        if (rx_data[m_t / LSPAN] != pat((m_t % LSPAN) - LOOP_LAT) && int'(m_err) != ERR_MAX)
          m_err <= m_err + 1'b1;
      end else if ((m_t % LSPAN) == LOOP_LAT + WIN) begin
        m_err_o               <= m_err;
        m_lane_o              <= LW'(m_t / LSPAN);
        m_pass[m_t / LSPAN]   <= (m_err == '0);
        m_err                 <= '0;
      end
    end
  end

  always_comb begin
    exp_tx = '0;
    if (m_active && m_t < TOT && (m_t % LSPAN) < LOOP_LAT + WIN)
      exp_tx = LANES'(pat(m_t % LSPAN)) << (m_t / LSPAN);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("tx_data",   32'(tx_data),   32'(exp_tx));
      chk("busy",      32'(busy),      32'(m_active));
      chk("done",      32'(done),      32'(m_active && m_t == TOT));
      chk("lane_o",    32'(lane_o),    32'(m_lane_o));
      chk("err_cnt_o", 32'(err_cnt_o), 32'(m_err_o));
      chk("pass_mask", 32'(pass_mask), 32'(m_pass));
    end
  end

  // Loopback channel: rx = tx delayed loop_dly cycles, with optional faults.
  int               loop_dly = LOOP_LAT;
  int               fault = 0;   // 0 none, 1 single inverted bit on lane 2, 2 lane 1 stuck at 0
  logic [LANES-1:0] hist [0:7];
  initial for (int i = 0; i < 8; i++) hist[i] = '0;

  always @(negedge clk) begin
    logic [LANES-1:0] r;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = tx_data;
    r = hist[loop_dly];
    if (fault == 1 && m_active && m_t == 2 * LSPAN + LOOP_LAT + 5) r[2] = ~r[2];
    if (fault == 2) r[1] = 1'b0;
    rx_data = r;
  end

  int cap [0:3];
  int lat;

  task automatic sweep();
    logic [LW-1:0] prev;
    for (int i = 0; i < 4; i++) cap[i] = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    prev = lane_o;
    lat = 0;
    while (done !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
      if (lane_o != prev) begin
        cap[lane_o] = int'(err_cnt_o);
        prev = lane_o;
      end
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  int nd;

  initial begin
    #1 rst = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pass", 32'(pass_mask), 32'd0);
    chk("rst_tx",   32'(tx_data), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);

    // clean loopback
    sweep();
    chk("clean_latency", 32'(lat), 32'd84);
    chk("clean_pass",    32'(pass_mask), 32'hF);
    chk("clean_err",     32'(err_cnt_o), 32'd0);
    chk("clean_lane",    32'(lane_o), 32'd3);
    chk("busy_in_done",  32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_after",    32'(busy), 32'd0);
    repeat (3) @(negedge clk);

    // one inverted rx bit on lane 2
    fault = 1;
    sweep();
    chk("inv_pass",  32'(pass_mask), 32'hB);
    chk("inv_err_l2", 32'(cap[2]), 32'd1);
    fault = 0;
    repeat (3) @(negedge clk);

    // lane 1 stuck at 0: 8 mismatches saturate a 3-bit counter
    fault = 2;
    sweep();
    chk("stuck_pass",   32'(pass_mask), 32'hD);
    chk("stuck_err_l1", 32'(cap[1]), 32'd7);
    fault = 0;
    repeat (3) @(negedge clk);

    // loop delay one cycle too long
    loop_dly = 5;
    sweep();
    chk("dly5_pass",   32'(pass_mask), 32'h0);
    chk("dly5_err_nz", 32'(err_cnt_o != '0), 32'd1);
    loop_dly = LOOP_LAT;
    repeat (8) @(negedge clk);

    // abort during lane 2 CHECK
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (50) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tx",   32'(tx_data), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_pass", 32'(pass_mask), 32'h3);
    nd = 0;
    repeat (100) begin @(negedge clk); if (done) nd++; end
    chk("abort_no_done", 32'(nd), 32'd0);

    // start while busy and in the DONE cycle
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 300) begin @(negedge clk); lat++; end
    chk("busy_start_done", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    nd = 0;
    repeat (100) begin if (done) nd++; @(negedge clk); end
    chk("single_done",  32'(nd), 32'd0);
    chk("idle_after",   32'(busy), 32'd0);

    // asynchronous reset mid-sweep
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tx",   32'(tx_data), 32'd0);
    chk("arst_pass", 32'(pass_mask), 32'd0);
    chk("arst_lane", 32'(lane_o), 32'd0);
    chk("arst_err",  32'(err_cnt_o), 32'd0);
    @(negedge clk) rst = 1'b1;
    nd = 0;
    repeat (100) begin @(negedge clk); if (done) nd++; end
    chk("arst_no_done", 32'(nd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
